maxpool2d_stream: RTL and testbench

Streaming 2x2/stride-2 max-pool stage directly downstream of `conv2d`. It consumes that stage's output feature map serialized as a raster-order pixel stream, one pixel per accepted beat, and emits the pooled map in the same raster order. A half-width line buffer holds partial maxima between row pairs, so no full-frame storage is needed. It feeds the next `conv2d` or the flatten/dense stage.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/pool_line_buf.sv | 33 +++
 rtl/maxpool2d_stream.sv | 156 +++++++++++++++
 tb/tb_maxpool2d_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: types, constants and helpers shared by the CNN streaming stages.
//   PIXEL_W        : default pixel width (two's-complement signed)
//   pixel_t        : signed pixel type, PIXEL_W bits
//   POOL_K, POOL_S : pooling window and stride
//   max2()         : signed maximum of two pixels
//   pool_out_dim() : output dimension of a 2x2/stride-2 pool, also used for
//                    flatten/dense sizing
package cnn_pkg;

   localparam int PIXEL_W = 8;
   localparam int POOL_K  = 2;
   localparam int POOL_S  = 2;

   typedef logic signed [PIXEL_W-1:0] pixel_t;

   function automatic pixel_t max2(input pixel_t a, input pixel_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic int pool_out_dim(input int n);
      return n / POOL_S;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: holds one row of horizontal pair maxima between the two rows
// of a pooling row pair. Synchronous write, combinational read, no reset
// (every entry is written before it is read within each row pair).
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   waddr_i : write address (pair index, col/2)
//   wdata_i : pair maximum to store
//   raddr_i : read address
//   rdata_o : stored pair maximum at raddr_i
module pool_line_buf #(
   parameter int DEPTH      = 14,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_W     = 4
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream: streaming 2x2/stride-2 max-pool over a raster-order,
// channel-major pixel stream. Emits pooled pixels in raster order.
// Optional build macro: MAXPOOL_RELU_EN fuses a ReLU after the block max.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   in_valid  : input pixel valid          in_ready : stage accepts a pixel
//   in_data   : input pixel (signed)
//   out_valid : pooled pixel valid         out_ready: downstream accepts it
//   out_data  : pooled pixel (signed)      out_last : final pixel of frame
//   busy      : frame partially received or output pending
module maxpool2d_stream
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = PIXEL_W,
   parameter int CHANNELS   = 1,
   parameter int HEIGHT     = 28,
   parameter int WIDTH      = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy
);

   localparam int LB_DEPTH = pool_out_dim(WIDTH);
   localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int COL_W    = $clog2(WIDTH);
   localparam int ROW_W    = $clog2(HEIGHT);
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef logic signed [DATA_WIDTH-1:0] dpix_t;

   function automatic dpix_t smax(input dpix_t a, input dpix_t b);
      return (a > b) ? a : b;
   endfunction

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [CH_W-1:0]  ch_q,  ch_d;
   dpix_t            h_q,   h_d;
   logic             out_valid_q, out_valid_d;
   dpix_t            out_data_q,  out_data_d;
   logic             out_last_q,  out_last_d;

   logic             in_xfer, out_xfer;
   logic             col_last, row_last, ch_last;
   logic             lb_we;
   logic [LB_AW-1:0] lb_addr;
   logic [DATA_WIDTH-1:0] lb_rd;
   dpix_t            pair_max, block_max, pooled;

   assign in_ready = !out_valid_q || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   assign col_last = (col_q == COL_W'(WIDTH - 1));
   assign row_last = (row_q == ROW_W'(HEIGHT - 1));
   assign ch_last  = (ch_q == CH_W'(CHANNELS - 1));

   // Odd column closes a horizontal pair; even rows park it in the line
   // buffer, odd rows combine it with the parked pair from the row above.
   assign pair_max  = smax(h_q, $signed(in_data));
   assign block_max = smax($signed(lb_rd), pair_max);
   assign lb_we     = in_xfer && col_q[0] && !row_q[0];
   assign lb_addr   = LB_AW'(col_q >> 1);

`ifdef MAXPOOL_RELU_EN
   assign pooled = block_max[DATA_WIDTH-1] ? '0 : block_max;
`else
   assign pooled = block_max;
`endif

   pool_line_buf #(
      .DEPTH      (LB_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (LB_AW)
   ) u_line_buf (
      .clk_i   (clk),
      .we_i    (lb_we),
      .waddr_i (lb_addr),
      .wdata_i (pair_max),
      .raddr_i (lb_addr),
      .rdata_o (lb_rd)
   );

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      ch_d        = ch_q;
      h_d         = h_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (in_xfer) begin
         if (col_last) begin
            col_d = '0;
            if (row_last) begin
               row_d = '0;
               ch_d  = ch_last ? '0 : ch_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_q[0]) begin
            h_d = $signed(in_data);
         end
      end

      if (out_xfer) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      // A completing block overrides the drain above, so a same-cycle
      // output transfer and block completion keep out_valid high.
      if (in_xfer && col_q[0] && row_q[0]) begin
         out_valid_d = 1'b1;
         out_data_d  = pooled;
         out_last_d  = ch_last && row_last && col_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         ch_q        <= '0;
         h_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         ch_q        <= ch_d;
         h_q         <= h_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (col_q != '0) || (row_q != '0) || (ch_q != '0) || out_valid_q;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb_maxpool2d_stream: three instances of maxpool2d_stream
//   0: 4x4x1, 1: 2x2x2, 2: 28x28x4
// driven from a block-level reference model (2x2 window maxima over the whole
// frame, optional ReLU when MAXPOOL_RELU_EN is defined).
module tb_maxpool2d_stream;

   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst       [3];
   logic                 in_valid  [3];
   logic                 in_ready  [3];
   logic signed [DW-1:0] in_data   [3];
   logic                 out_valid [3];
   logic                 out_ready [3];
   logic signed [DW-1:0] out_data  [3];
   logic                 out_last  [3];
   logic                 busy      [3];

   maxpool2d_stream #(.DATA_WIDTH(DW), .CHANNELS(1), .HEIGHT(4), .WIDTH(4)) u_dut_a (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]));

   maxpool2d_stream #(.DATA_WIDTH(DW), .CHANNELS(2), .HEIGHT(2), .WIDTH(2)) u_dut_b (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]));

   maxpool2d_stream #(.DATA_WIDTH(DW), .CHANNELS(4), .HEIGHT(28), .WIDTH(28)) u_dut_c (
      .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .out_last(out_last[2]), .busy(busy[2]));

   int n_checks = 0;
   int n_errors = 0;

   int pix_q [$];
   int exp_d [$];
   int exp_l [$];
   int exp_i [$];

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int dim_w(input int id);
      case (id)
         0:       return 4;
         1:       return 2;
         default: return 28;
      endcase
   endfunction

   function automatic int dim_h(input int id);
      case (id)
         0:       return 4;
         1:       return 2;
         default: return 28;
      endcase
   endfunction

   function automatic int dim_c(input int id);
      case (id)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   // Reference: each output is the max over a 2x2 window of the frame, in
   // raster order per channel; it becomes visible once the window's
   // bottom-right pixel has been accepted.
   task automatic build_expected(input int id);
      int w, h, c, fsz, nfr;
      w = dim_w(id); h = dim_h(id); c = dim_c(id);
      fsz = w * h * c;
      nfr = pix_q.size() / fsz;
      exp_d.delete(); exp_l.delete(); exp_i.delete();
      for (int f = 0; f < nfr; f++)
         for (int ch = 0; ch < c; ch++)
            for (int br = 0; br < h / 2; br++)
               for (int bc = 0; bc < w / 2; bc++) begin
                  int base, m;
                  base = f * fsz + ch * h * w + 2 * br * w + 2 * bc;
                  m = pix_q[base];
                  if (pix_q[base + 1] > m)     m = pix_q[base + 1];
                  if (pix_q[base + w] > m)     m = pix_q[base + w];
                  if (pix_q[base + w + 1] > m) m = pix_q[base + w + 1];
`ifdef MAXPOOL_RELU_EN
                  if (m < 0) m = 0;
`endif
                  exp_d.push_back(m);
                  exp_l.push_back((ch == c - 1 && br == h / 2 - 1 && bc == w / 2 - 1) ? 1 : 0);
                  exp_i.push_back(base + w + 1);
               end
   endtask

   task automatic do_reset(input int id);
      rst[id] = 1'b1;
      in_valid[id] = 1'b0;
      out_ready[id] = 1'b1;
      #1;
      check_eq("rst_out_valid", int'(out_valid[id]), 0);
      check_eq("rst_out_data", int'(out_data[id]), 0);
      check_eq("rst_out_last", int'(out_last[id]), 0);
      check_eq("rst_busy", int'(busy[id]), 0);
      check_eq("rst_in_ready", int'(in_ready[id]), 1);
      @(posedge clk); #1;
      rst[id] = 1'b0;
      #1;
      check_eq("post_rst_out_valid", int'(out_valid[id]), 0);
      check_eq("post_rst_in_ready", int'(in_ready[id]), 1);
      check_eq("post_rst_busy", int'(busy[id]), 0);
   endtask

   task automatic idle_check(input int id);
      in_valid[id] = 1'b0;
      out_ready[id] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("idle_out_valid", int'(out_valid[id]), 0);
         check_eq("idle_busy", int'(busy[id]), 0);
         check_eq("idle_in_ready", int'(in_ready[id]), 1);
      end
   endtask

   // vmode: 0 in_valid always, 1 random. rmode: 0 out_ready always,
   // 1 random, 2 never. stall_len: out_ready forced low that many cycles
   // from the first output seen.
   task automatic run_stream(input int id, input int vmode, input int rmode,
                             input int stall_len, input int bound, output int n_out);
      int idx, k, cyc, stall_left, held_d, held_l;
      bit pend, hold, stall_used;
      int acc [$];
      idx = 0; k = 0; cyc = 0; stall_left = 0; held_d = 0; held_l = 0;
      pend = 0; hold = 0; stall_used = 0;
      while ((idx < pix_q.size() || k < exp_d.size()) && cyc < bound) begin
         if (hold) begin
            check_eq("hold_valid", int'(out_valid[id]), 1);
            check_eq("hold_data", int'(out_data[id]), held_d);
            check_eq("hold_last", int'(out_last[id]), held_l);
         end
         if (out_valid[id] && !pend) begin
            pend = 1;
            if (k < exp_i.size()) begin
               if (exp_i[k] < acc.size())
                  check_eq("latency", cyc, acc[exp_i[k]] + 1);
               else
                  check_eq("early_out", acc.size(), exp_i[k] + 1);
            end
            if (stall_len > 0 && !stall_used) begin
               stall_left = stall_len;
               stall_used = 1;
            end
         end
         in_valid[id] = (idx < pix_q.size()) && (vmode == 0 || $urandom_range(0, 3) != 0);
         in_data[id]  = (idx < pix_q.size()) ? DW'(pix_q[idx]) : '0;
         case (rmode)
            0:       out_ready[id] = 1'b1;
            1:       out_ready[id] = ($urandom_range(0, 3) != 0);
            default: out_ready[id] = 1'b0;
         endcase
         if (stall_left > 0) begin
            out_ready[id] = 1'b0;
            stall_left--;
         end
         #1;
         if (out_valid[id] && !out_ready[id]) begin
            check_eq("stall_in_ready", int'(in_ready[id]), 0);
            hold = 1;
            held_d = int'(out_data[id]);
            held_l = int'(out_last[id]);
         end else begin
            hold = 0;
         end
         if (!out_valid[id]) check_eq("free_in_ready", int'(in_ready[id]), 1);
         if (out_valid[id] && out_ready[id]) begin
            if (k < exp_d.size()) begin
               check_eq("out_data", int'(out_data[id]), exp_d[k]);
               check_eq("out_last", int'(out_last[id]), exp_l[k]);
            end else begin
               check_eq("extra_out", k + 1, exp_d.size());
            end
            k++;
            pend = 0;
         end
         if (in_valid[id] && in_ready[id]) begin
            acc.push_back(cyc);
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid[id] = 1'b0;
      out_ready[id] = 1'b1;
      check_eq("inputs_consumed", idx, pix_q.size());
      check_eq("outputs_seen", k, exp_d.size());
      n_out = k;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_out;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b1; in_data[i] = '0;
      end
      for (int i = 0; i < 3; i++) do_reset(i);

      // 4x4 ramp 0..15, full throughput: 5, 7, 13, 15
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(i);
      build_expected(0);
      run_stream(0, 0, 0, 0, 200, n_out);
      check_eq("ramp_count", n_out, 4);
      idle_check(0);

      // negative block -3,-1,-8,-2 in the top-left window, rest random
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(int'($urandom_range(0, 255)) - 128);
      pix_q[0] = -3; pix_q[1] = -1; pix_q[4] = -8; pix_q[5] = -2;
      build_expected(0);
      run_stream(0, 0, 1, 0, 400, n_out);
      idle_check(0);

      // 5-cycle back-pressure on the first output, then resume
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(i);
      build_expected(0);
      run_stream(0, 0, 0, 5, 200, n_out);
      idle_check(0);

      // two channels, two back-to-back frames: 9, -4 (last) per frame
      pix_q.delete();
      for (int f = 0; f < 2; f++) begin
         pix_q.push_back(1);  pix_q.push_back(9);  pix_q.push_back(3);  pix_q.push_back(4);
         pix_q.push_back(-5); pix_q.push_back(-6); pix_q.push_back(-7); pix_q.push_back(-4);
      end
      build_expected(1);
      run_stream(1, 0, 0, 0, 200, n_out);
      check_eq("chan_count", n_out, 4);
      idle_check(1);

      // abort mid-frame with a pending output, then a clean frame
      pix_q.delete();
      for (int i = 0; i < 6; i++) pix_q.push_back(i);
      exp_d.delete(); exp_l.delete(); exp_i.delete();
      run_stream(0, 0, 2, 0, 100, n_out);
      do_reset(0);
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(i);
      build_expected(0);
      run_stream(0, 0, 0, 0, 200, n_out);
      check_eq("after_rst_count", n_out, 4);
      idle_check(0);

      // random 28x28x4 frame with random handshakes
      pix_q.delete();
      for (int i = 0; i < 28 * 28 * 4; i++) pix_q.push_back(int'($urandom_range(0, 255)) - 128);
      build_expected(2);
      run_stream(2, 1, 1, 0, 30000, n_out);
      check_eq("pooled_count", n_out, 14 * 14 * 4);
      idle_check(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
